// File: rtl/pong_engine.sv
// pong_engine: ball, paddle and score state with a registered 12-bit pixel stream.
// Ports: clk/reset_n, pix_en+x/y scan position, buttons, start -> rgb, score1/2, winner, state.
module pong_engine #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int BORDER       = 10,
  parameter int BALL_SIZE    = 10,
  parameter int PAD_W        = 8,
  parameter int PAD_H        = 96,
  parameter int PAD_OFF      = 20,
  parameter int PAD_SPEED    = 2,
  parameter int BALL_SPEED   = 2,
  parameter int MAX_SPEED    = 6,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_en,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        p1_up,
  input  logic        p1_down,
  input  logic        p2_up,
  input  logic        p2_down,
  input  logic        start,
  output logic [11:0] rgb,
  output logic [3:0]  score1,
  output logic [3:0]  score2,
  output logic [1:0]  winner,
  output logic [2:0]  state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } st_t;

  localparam logic [9:0]  HR    = 10'(H_RES);
  localparam logic [9:0]  VR    = 10'(V_RES);
  localparam logic [9:0]  BD    = 10'(BORDER);
  localparam logic [9:0]  BS    = 10'(BALL_SIZE);
  localparam logic [9:0]  PW    = 10'(PAD_W);
  localparam logic [9:0]  PH    = 10'(PAD_H);
  localparam logic [9:0]  L1    = 10'(PAD_OFF);
  localparam logic [9:0]  L1E   = 10'(PAD_OFF + PAD_W);
  localparam logic [9:0]  L2    = 10'(H_RES - PAD_OFF - PAD_W);
  localparam logic [9:0]  CX    = 10'((H_RES - BALL_SIZE) / 2);
  localparam logic [9:0]  CY    = 10'((V_RES - BALL_SIZE) / 2);
  localparam logic [9:0]  PY0   = 10'((V_RES - PAD_H) / 2);
  localparam logic [9:0]  PMAX  = 10'(V_RES - BORDER - PAD_H);
  localparam logic [9:0]  WB    = 10'(V_RES - BORDER);
  localparam logic [9:0]  BYMAX = 10'(V_RES - BORDER - BALL_SIZE);
  localparam logic [9:0]  PS    = 10'(PAD_SPEED);
  localparam logic [9:0]  BSP   = 10'(BALL_SPEED);
  localparam logic [9:0]  MSP   = 10'(MAX_SPEED);
  localparam logic [3:0]  WIN   = 4'(WIN_SCORE);
  localparam logic [15:0] SF    = 16'(SERVE_FRAMES);

  st_t        st;
  logic [15:0] cnt;
  logic [9:0] bx;
  logic [9:0] by;
  logic [9:0] spd;
  logic [9:0] p1_y;
  logic [9:0] p2_y;
  logic       dx;
  logic       dy;
  logic       srv_dx;

  logic       fs;
  logic       hit1;
  logic       hit2;
  logic       goal_l;
  logic       goal_r;
  logic [9:0] spd_up;
  logic [9:0] nx;
  logic [9:0] ny;
  logic [9:0] nspd;
  logic [9:0] np1;
  logic [9:0] np2;
  logic       ndx;
  logic       ndy;
  logic [3:0] s1_inc;
  logic [3:0] s2_inc;

  assign fs     = pix_en && (x == 10'd0) && (y == VR);
  assign state  = {1'b0, st};
  assign s1_inc = score1 + 4'd1;
  assign s2_inc = score2 + 4'd1;
  assign spd_up = (spd >= MSP) ? MSP : spd + 10'd1;

  function automatic logic [9:0] pad_step(
    input logic [9:0] p,
    input logic       up,
    input logic       dn
  );
    logic [9:0] r;
    r = p;
    if (up)
      r = (p < BD + PS) ? BD : p - PS;
    else if (dn)
      r = (p + PS > PMAX) ? PMAX : p + PS;
    return r;
  endfunction

  assign np1 = pad_step(p1_y, p1_up, p1_down);
  assign np2 = pad_step(p2_y, p2_up, p2_down);

  always_comb begin
    hit1   = !dx && (bx - spd <= L1E) && (bx >= L1E)
          && (by + BS > p1_y) && (by < p1_y + PH);
    hit2   = dx && (bx + BS + spd >= L2) && (bx + BS <= L2)
          && (by + BS > p2_y) && (by < p2_y + PH);
    goal_l = !dx && (bx <= spd);
    goal_r = dx && (bx + BS + spd >= HR);
    nx   = dx ? bx + spd : bx - spd;
    ndx  = dx;
    nspd = spd;
    unique case (1'b1)
      hit1: begin
        nx   = L1E;
        ndx  = 1'b1;
        nspd = spd_up;
      end
      hit2: begin
        nx   = L2 - BS;
        ndx  = 1'b0;
        nspd = spd_up;
      end
      default: ;
    endcase
    // walls only act on a ball heading into them, so a clamped ball leaves
    ny  = dy ? by + BSP : by - BSP;
    ndy = dy;
    if (dy && (by + BS + BSP >= WB)) begin
      ny  = BYMAX;
      ndy = 1'b0;
    end else if (!dy && (by <= BD + BSP)) begin
      ny  = BD;
      ndy = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st     <= IDLE;
      cnt    <= '0;
      bx     <= CX;
      by     <= CY;
      dx     <= 1'b1;
      dy     <= 1'b1;
      spd    <= BSP;
      srv_dx <= 1'b1;
      p1_y   <= PY0;
      p2_y   <= PY0;
      score1 <= '0;
      score2 <= '0;
      winner <= '0;
    end else if (fs) begin
      if (st != OVER) begin
        p1_y <= np1;
        p2_y <= np2;
      end
      unique case (st)
        IDLE: begin
          if (start) begin
            st  <= SERVE;
            cnt <= SF;
            bx  <= CX;
            by  <= CY;
            dx  <= srv_dx;
            dy  <= 1'b1;
            spd <= BSP;
          end
        end
        SERVE: begin
          if (cnt <= 16'd1)
            st <= PLAY;
          else
            cnt <= cnt - 16'd1;
        end
        PLAY: begin
          by <= ny;
          dy <= ndy;
          if (goal_l) begin
            score2 <= s2_inc;
            srv_dx <= 1'b0;
            if (s2_inc == WIN) begin
              winner <= 2'd2;
              st     <= OVER;
            end else begin
              st  <= SERVE;
              cnt <= SF;
              bx  <= CX;
              by  <= CY;
              dx  <= 1'b0;
              dy  <= 1'b1;
              spd <= BSP;
            end
          end else if (goal_r) begin
            score1 <= s1_inc;
            srv_dx <= 1'b1;
            if (s1_inc == WIN) begin
              winner <= 2'd1;
              st     <= OVER;
            end else begin
              st  <= SERVE;
              cnt <= SF;
              bx  <= CX;
              by  <= CY;
              dx  <= 1'b1;
              dy  <= 1'b1;
              spd <= BSP;
            end
          end else begin
            bx  <= nx;
            dx  <= ndx;
            spd <= nspd;
          end
        end
        OVER: begin
          if (start) begin
            score1 <= '0;
            score2 <= '0;
            winner <= '0;
            srv_dx <= 1'b1;
            st     <= SERVE;
            cnt    <= SF;
            bx     <= CX;
            by     <= CY;
            dx     <= 1'b1;
            dy     <= 1'b1;
            spd    <= BSP;
          end
        end
        default: ;
      endcase
    end
  end

  logic show;
  logic on_bd;
  logic on_p1;
  logic on_p2;
  logic on_ball;
  logic white;

  always_comb begin
    show    = (st == SERVE) || (st == PLAY);
    on_bd   = (y < BD) || (y >= WB);
    on_p1   = (x >= L1) && (x < L1 + PW)
           && (y >= p1_y) && (y < p1_y + PH);
    on_p2   = (x >= L2) && (x < L2 + PW)
           && (y >= p2_y) && (y < p2_y + PH);
    on_ball = show && (x >= bx) && (x < bx + BS)
           && (y >= by) && (y < by + BS);
    white   = (x < HR) && (y < VR)
           && (on_bd || on_p1 || on_p2 || on_ball);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rgb <= '0;
    else
      rgb <= white ? 12'hfff : 12'h000;
  end

endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: scoreboard bench for pong_engine driving x/y directly.
// A behavioural game model predicts every probed pixel and status output.
module tb_pong_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pix_en = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        p1_up = 1'b0;
  logic        p1_down = 1'b0;
  logic        p2_up = 1'b0;
  logic        p2_down = 1'b0;
  logic        start = 1'b0;
  logic [11:0] rgb;
  logic [3:0]  score1;
  logic [3:0]  score2;
  logic [1:0]  winner;
  logic [2:0]  state;

  pong_engine dut (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .x(x), .y(y),
    .p1_up(p1_up), .p1_down(p1_down),
    .p2_up(p2_up), .p2_down(p2_down),
    .start(start), .rgb(rgb),
    .score1(score1), .score2(score2),
    .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  logic [11:0] exp_q[$];

  int m_st, m_cnt, m_bx, m_by, m_dx, m_dy, m_spd;
  int m_p1, m_p2, m_s1, m_s2, m_win, m_srv;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_st = 0; m_cnt = 0; m_bx = 315; m_by = 235;
    m_dx = 1; m_dy = 1; m_spd = 2; m_srv = 1;
    m_p1 = 192; m_p2 = 192; m_s1 = 0; m_s2 = 0; m_win = 0;
  endtask

  task automatic serve_go();
    m_st = 1; m_cnt = 60; m_bx = 315; m_by = 235;
    m_dx = m_srv; m_dy = 1; m_spd = 2;
  endtask

  function automatic int pad(input int p, input logic u, input logic d);
    if (u) return (p - 2 < 10) ? 10 : p - 2;
    if (d) return (p + 2 > 374) ? 374 : p + 2;
    return p;
  endfunction

  task automatic model_fs();
    int old, ox, oy, g;
    old = m_st; ox = m_bx; oy = m_by; g = 0;
    case (m_st)
      0: if (start) serve_go();
      1: if (m_cnt <= 1) m_st = 2; else m_cnt--;
      2: begin
        if (m_dx == 0 && ox - m_spd <= 28 && ox >= 28
            && oy + 10 > m_p1 && oy < m_p1 + 96) begin
          m_bx = 28; m_dx = 1;
          m_spd = (m_spd < 6) ? m_spd + 1 : 6;
        end else if (m_dx == 1 && ox + 10 + m_spd >= 612
            && ox + 10 <= 612 && oy + 10 > m_p2 && oy < m_p2 + 96) begin
          m_bx = 602; m_dx = 0;
          m_spd = (m_spd < 6) ? m_spd + 1 : 6;
        end else if (m_dx == 0 && ox <= m_spd) g = 2;
        else if (m_dx == 1 && ox + 10 + m_spd >= 640) g = 1;
        else m_bx = m_dx ? ox + m_spd : ox - m_spd;
        if (m_dy == 1 && oy + 12 >= 470) begin
          m_by = 460; m_dy = 0;
        end else if (m_dy == 0 && oy <= 12) begin
          m_by = 10; m_dy = 1;
        end else m_by = m_dy ? oy + 2 : oy - 2;
        if (g == 2) begin
          m_s2++; m_srv = 0;
          if (m_s2 == 7) begin m_win = 2; m_st = 3; end
          else serve_go();
        end
        if (g == 1) begin
          m_s1++; m_srv = 1;
          if (m_s1 == 7) begin m_win = 1; m_st = 3; end
          else serve_go();
        end
      end
      default: if (start) begin
        m_s1 = 0; m_s2 = 0; m_win = 0; m_srv = 1;
        serve_go();
      end
    endcase
    if (old != 3) begin
      m_p1 = pad(m_p1, p1_up, p1_down);
      m_p2 = pad(m_p2, p2_up, p2_down);
    end
  endtask

  function automatic logic [11:0] m_rgb(input int px, input int py);
    logic w;
    if (px < 0 || px >= 640 || py < 0 || py >= 480) return 12'h000;
    w = (py < 10) || (py >= 470);
    w |= px >= 20 && px < 28 && py >= m_p1 && py < m_p1 + 96;
    w |= px >= 612 && px < 620 && py >= m_p2 && py < m_p2 + 96;
    w |= (m_st == 1 || m_st == 2) && px >= m_bx && px < m_bx + 10
         && py >= m_by && py < m_by + 10;
    return w ? 12'hfff : 12'h000;
  endfunction

  task automatic pix(input logic en, input int px, input int py);
    pix_en = en; x = 10'(px); y = 10'(py);
    exp_q.push_back(m_rgb(px, py));
    @(posedge clk);
    if (en && px == 0 && py == 480) model_fs();
    #1;
    chk($sformatf("rgb(%0d,%0d)", px, py), rgb, exp_q.pop_front());
  endtask

  task automatic probe();
    pix(1, m_bx, m_by);
    pix(1, m_bx - 1, m_by);
    pix(1, m_bx + 9, m_by + 9);
    pix(1, m_bx + 10, m_by + 9);
    pix(1, m_bx + 9, m_by + 10);
    pix(1, 20, m_p1);
    pix(1, 20, m_p1 - 1);
    pix(1, 27, m_p1 + 96);
    pix(1, 612, m_p2 + 95);
    pix(1, 619, m_p2 - 1);
    pix(1, 619, m_p2 + 96);
    chk("state", state, m_st);
    chk("score1", score1, m_s1);
    chk("score2", score2, m_s2);
    chk("winner", winner, m_win);
  endtask

  task automatic frame(input logic s, input logic u1, input logic d1,
                       input logic u2, input logic d2);
    start = s; p1_up = u1; p1_down = d1; p2_up = u2; p2_down = d2;
    pix(1, 0, 480);
    probe();
  endtask

  // paddle tracking the ball centre
  task automatic ai_frame(input logic s, input logic dodge);
    logic u1, d1, u2, d2;
    u2 = (m_p2 + 48 > m_by + 5);
    d2 = (m_p2 + 48 < m_by + 5);
    if (dodge) begin
      u1 = (m_by >= 235);
      d1 = !u1;
    end else begin
      u1 = (m_p1 + 48 > m_by + 5);
      d1 = (m_p1 + 48 < m_by + 5);
    end
    frame(s, u1, d1, u2, d2);
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", rgb, 0);
    chk("rst_state", state, 0);
    chk("rst_s1", score1, 0);
    chk("rst_s2", score2, 0);
    chk("rst_win", winner, 0);
    @(negedge clk);
    reset_n = 1'b1;

    repeat (3) frame(0, 0, 0, 0, 0);
    pix(1, 640, 5);
    pix(1, 700, 500);
    pix(1, 5, 479);
    pix(1, 5, 470);
    pix(1, 5, 469);
    pix(1, 5, 9);
    pix(1, 5, 10);
    pix(0, 0, 480);
    pix(1, 1, 480);
    probe();

    repeat (100) frame(0, 1, 0, 0, 1);
    repeat (5) frame(0, 0, 0, 1, 1);

    ai_frame(1, 0);
    chk("serve_state", state, 1);
    pix(0, 0, 480);
    probe();

    n = 0;
    while (m_spd != 6 && n < 1500) begin
      ai_frame(0, 0);
      n++;
    end
    chk("spd_budget", n >= 1500, 0);
    repeat (200) ai_frame(0, 0);

    n = 0;
    while (m_win == 0 && n < 3000) begin
      ai_frame(0, 1);
      n++;
    end
    chk("win_budget", n >= 3000, 0);
    chk("winner_p2", winner, 2);
    chk("over_state", state, 3);

    repeat (3) frame(0, 1, 0, 0, 1);
    ai_frame(1, 0);
    chk("restart_state", state, 1);
    chk("restart_s2", score2, 0);
    chk("restart_win", winner, 0);

    n = 0;
    while (m_s2 == 0 && n < 1500) begin
      ai_frame(0, 1);
      n++;
    end
    chk("point_budget", n >= 1500, 0);
    repeat (70) ai_frame(0, 0);
    chk("play_state", state, 2);

    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_rgb", rgb, 0);
    chk("mid_rst_state", state, 0);
    chk("mid_rst_s2", score2, 0);
    chk("mid_rst_win", winner, 0);
    m_reset();
    @(negedge clk);
    reset_n = 1'b1;
    frame(0, 0, 0, 0, 0);
    pix(1, 20, 191);
    pix(1, 20, 192);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
